systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Sequencer for an N×N output-stationary systolic array of int8 processing elements (multiply-accumulate, 16-bit accumulator, operands forwarded one PE per cycle). On `start` it clears the array, fetches K operand vectors from the A/B operand buffers, skews them per row/column and drives the array edges with zero-padding. It then waits for the wavefront to drain and flags when all N² accumulators hold the final C = A·B. It sits between the operand buffers and the array's edge inputs.

## Interface
- `N`, 4, array dimension (rows = columns)
- `KMAX`, 16, maximum inner dimension
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request; accepted only in IDLE
- `k_len`  in  $clog2(KMAX+1)  inner dimension, sampled when start is accepted; valid range 0..KMAX
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse, coincident with res_valid
- `rd_en`  out  1  operand buffer read strobe
- `rd_addr`  out  $clog2(KMAX)  k index; buffers return data the cycle after rd_en (1-cycle latency)
- `a_rdata`  in  N*8  column k of A; row i at [8i+:8]
- `b_rdata`  in  N*8  row k of B; column j at [8j+:8]
- `x_edge`  out  N*8  row i west-edge operand, signed int8
- `y_edge`  out  N*8  column j north-edge operand, signed int8
- `pe_clr`  out  1  array synchronous clear; equals rst OR (state==CLEAR)
- `res_valid`  out  1  array results are final this cycle

## Operation
- States: IDLE → CLEAR → FEED → FLUSH → DONE → IDLE.
- IDLE: if start, latch k_len and go to CLEAR.
- CLEAR: 1 cycle with pe_clr=1. Go to FEED if k_len≠0, else DONE.
- FEED: k_len cycles. rd_en=1, rd_addr=0,1,…,k_len−1. Go to FLUSH after rd_addr=k_len−1.
- FLUSH: 2N−1 cycles with rd_en=0, counted by a down-counter. Then go to DONE.
- DONE: 1 cycle with res_valid=1 and done=1, then IDLE. Array results hold until the next CLEAR.
- Data valid is rd_en delayed by 1 cycle, and travels alongside the data.
- Skew: row i of a_rdata passes through i register stages; column j of b_rdata passes through j stages. Row 0 and column 0 are combinational from rdata.
- Edge lanes output 0 whenever their delayed valid is 0, so bubbles add nothing to the accumulators.
- start is ignored outside IDLE, including during DONE.
- No saturation: accumulators wrap mod 2^16, and the controller does not detect overflow.
- rst mid-operation: next state IDLE, rd_en=0, all skew stages and valids cleared, pe_clr=1 throughout rst.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, x_edge=0, y_edge=0, res_valid=0, pe_clr=1 (follows rst).
- Cycle numbering: start sampled high in IDLE at cycle s.
  - CLEAR: s+1.
  - FEED: s+2 … s+k_len+1.
  - FLUSH: s+k_len+2 … s+k_len+2N.
  - DONE: s+k_len+2N+1.
  - With k_len=0, DONE is at s+2.
- Derivation: an element read at cycle c reaches PE(i,j) at cycle c+1+i+j and is accumulated at the end of that cycle. The latest case is c+2N−1, so results are final in cycle c+2N, which is the DONE cycle.
- busy rises at s+1 and falls at the cycle after DONE.

## Structure
- Package `systolic_pkg`:
  - `DATA_W=8`, `ACC_W=16`
  - `state_t` enum {IDLE, CLEAR, FEED, FLUSH, DONE}
  - `FLUSH_LEN(N)=2N−1` function
- Sub-module `skew_line` (parameter DEPTH, DATA_W): shift register carrying data plus valid, with synchronous clear.
  - Instantiated N times for rows (DEPTH=i) and N times for columns (DEPTH=j).
  - DEPTH=0 is a pass-through.
- Top level holds the FSM, the k/flush counters and the edge zero-masking.

## Test plan
- N=4, K=4, A=identity, B[k][j]=4k+j+1 → PE(i,j)=4i+j+1. res_valid and done at s+13, exactly one cycle.
- K=1, every A entry 2, every B entry −3 → all 16 results −6. DONE at s+10. x_edge/y_edge are 0 in every cycle except each lane's single valid slot.
- k_len=0 → CLEAR at s+1, DONE at s+2, rd_en never asserted, all results 0.
- K=2, all operands −128 → 2×16384 wraps to −32768 in every PE, with no flag.
- rst asserted at the 2nd FEED cycle for 1 cycle → next cycle IDLE, busy=0, rd_en=0, edges 0. A fresh start with K=4 then gives correct identity results.
- start held high through the whole run → only one run occurs; start in the DONE cycle is ignored, and the next run begins only when start is seen in IDLE.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } state_t;

  // Cycles for the last operand to cross an n x n array after the final read.
  function automatic int FLUSH_LEN(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_line.sv
// Data+valid delay line of DEPTH stages with synchronous clear; DEPTH=0 is a wire.
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              vin,
  output logic [DATA_W-1:0] dout,
  output logic              vout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
      assign vout = vin;
    end else begin : g_shift
      logic [DATA_W-1:0] data_reg [DEPTH];
      logic [DEPTH-1:0]  valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int d = 0; d < DEPTH; d++) data_reg[d] <= '0;
          valid_reg <= '0;
        end else begin
          data_reg[0]  <= din;
          valid_reg[0] <= vin;
          for (int d = 1; d < DEPTH; d++) begin
            data_reg[d]  <= data_reg[d-1];
            valid_reg[d] <= valid_reg[d-1];
          end
        end
      end

      assign dout = data_reg[DEPTH-1];
      assign vout = valid_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clear, feed K skewed
// operand vectors with zero-masked bubbles, drain the wavefront, flag results.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int KMAX = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(KMAX+1)-1:0] k_len,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [$clog2(KMAX)-1:0]   rd_addr,
  input  logic [N*DATA_W-1:0]       a_rdata,
  input  logic [N*DATA_W-1:0]       b_rdata,
  output logic [N*DATA_W-1:0]       x_edge,
  output logic [N*DATA_W-1:0]       y_edge,
  output logic                      pe_clr,
  output logic                      res_valid
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int AW = $clog2(KMAX);
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN(N) - 1);

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_len_reg;
  logic [AW-1:0]   addr_reg;
  logic [FW-1:0]   flush_reg;
  logic            rd_valid_reg;
  logic            feed_last;

  assign feed_last = (KW'(addr_reg) == k_len_reg - KW'(1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = (k_len_reg != '0) ? FEED : DONE;
      FEED:    if (feed_last) state_next = FLUSH;
      FLUSH:   if (flush_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    res_valid = (state_reg == DONE);
    rd_en     = (state_reg == FEED) && !rst;
    pe_clr    = rst || (state_reg == CLEAR);
  end

  // k index runs only in FEED; flush counter preloads until FLUSH starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_len_reg    <= '0;
      addr_reg     <= '0;
      flush_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && start) k_len_reg <= k_len;
      if (state_reg == FEED) addr_reg <= addr_reg + AW'(1);
      else                   addr_reg <= '0;
      if (state_reg == FLUSH) flush_reg <= flush_reg - FW'(1);
      else                    flush_reg <= FLUSH_LAST;
      rd_valid_reg <= rd_en;
    end
  end

  assign rd_addr = addr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_W-1:0] a_dly, b_dly;
      logic              a_vld, b_vld;

      skew_line #(.DEPTH(gi), .DATA_W(DATA_W)) u_row (
        .clk  (clk),
        .rst  (rst),
        .din  (a_rdata[DATA_W*gi +: DATA_W]),
        .vin  (rd_valid_reg),
        .dout (a_dly),
        .vout (a_vld)
      );

      skew_line #(.DEPTH(gi), .DATA_W(DATA_W)) u_col (
        .clk  (clk),
        .rst  (rst),
        .din  (b_rdata[DATA_W*gi +: DATA_W]),
        .vin  (rd_valid_reg),
        .dout (b_dly),
        .vout (b_vld)
      );

      // Bubbles must contribute nothing to the accumulators.
      assign x_edge[DATA_W*gi +: DATA_W] = a_vld ? a_dly : '0;
      assign y_edge[DATA_W*gi +: DATA_W] = b_vld ? b_dly : '0;
    end
  endgenerate

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: operand buffers and a 4x4 MAC array are modelled
// here so end-to-end products can be checked against hand-computed C values.
module tb_systolic_seq_ctrl;

  localparam int N    = 4;
  localparam int KMAX = 16;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int AW   = $clog2(KMAX);

  logic            clk = 1'b0;
  logic            rst, start;
  logic [KW-1:0]   k_len;
  logic            busy, done, rd_en, pe_clr, res_valid;
  logic [AW-1:0]   rd_addr;
  logic [N*8-1:0]  a_rdata, b_rdata, x_edge, y_edge;

  systolic_seq_ctrl #(.N(N), .KMAX(KMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .a_rdata   (a_rdata),
    .b_rdata   (b_rdata),
    .x_edge    (x_edge),
    .y_edge    (y_edge),
    .pe_clr    (pe_clr),
    .res_valid (res_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Operand buffers: 1-cycle read latency, junk on the bus when not reading.
  logic signed [7:0] a_mem [KMAX][N];
  logic signed [7:0] b_mem [KMAX][N];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      a_rdata[8*i +: 8] <= rd_en ? a_mem[rd_addr][i] : 8'h5A;
      b_rdata[8*i +: 8] <= rd_en ? b_mem[rd_addr][i] : 8'hA5;
    end
  end

  // Output-stationary MAC array: x flows east, y flows south, one PE per cycle.
  logic signed [15:0] acc [N][N];
  logic signed [7:0]  xr [N][N];
  logic signed [7:0]  yr [N][N];
  logic signed [7:0]  xin [N][N];
  logic signed [7:0]  yin [N][N];
  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        xin[i][j] = (j == 0) ? $signed(x_edge[8*i +: 8]) : xr[i][(j > 0) ? j-1 : 0];
        yin[i][j] = (i == 0) ? $signed(y_edge[8*j +: 8]) : yr[(i > 0) ? i-1 : 0][j];
      end
  end
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (pe_clr) begin
          acc[i][j] <= '0;
          xr[i][j]  <= '0;
          yr[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + xin[i][j] * yin[i][j];
          xr[i][j]  <= xin[i][j];
          yr[i][j]  <= yin[i][j];
        end
      end
  end

  // a_kind: 0 identity, 1 constant a_c; b_kind: 0 B[k][j]=4k+j+1, 1 constant b_c
  // c_kind: 0 C[i][j]=4i+j+1, 1 constant c_c; exp_done is DONE offset from s.
  typedef struct {
    int k;
    int a_kind;
    int a_c;
    int b_kind;
    int b_c;
    int exp_done;
    int c_kind;
    int c_c;
  } vec_t;

  vec_t vecs [6];

  task automatic load(input vec_t v);
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < N; i++) begin
        a_mem[k][i] = (v.a_kind == 0) ? ((k == i) ? 8'sd1 : 8'sd0) : 8'(v.a_c);
        b_mem[k][i] = (v.b_kind == 0) ? 8'(4*k + i + 1) : 8'(v.b_c);
      end
  endtask

  task automatic run(input vec_t v, input string tag, input bit hold);
    int rd_cnt, done_off, c_exp;
    int xc [N];
    int yc [N];
    rd_cnt   = 0;
    done_off = -1;
    for (int i = 0; i < N; i++) begin xc[i] = 0; yc[i] = 0; end
    load(v);
    @(negedge clk);
    k_len = KW'(v.k);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int off = 1; off <= 100 && done_off < 0; off++) begin
      @(negedge clk);
      if (off == 1) begin
        chk({tag, " clear_pe_clr"}, pe_clr, 1);
        chk({tag, " clear_busy"}, busy, 1);
      end
      if (rd_en) begin
        chk({tag, " rd_addr"}, rd_addr, rd_cnt);
        rd_cnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (x_edge[8*i +: 8] != 8'd0) xc[i]++;
        if (y_edge[8*i +: 8] != 8'd0) yc[i]++;
      end
      if (done) begin
        chk({tag, " res_valid_with_done"}, res_valid, 1);
        done_off = off;
      end
    end
    chk({tag, " done_cycle"}, done_off, v.exp_done);
    chk({tag, " rd_count"}, rd_cnt, v.k);
    if (v.a_kind == 1 && v.b_kind == 1)
      for (int i = 0; i < N; i++) begin
        chk({tag, " x_edge_slots"}, xc[i], v.k);
        chk({tag, " y_edge_slots"}, yc[i], v.k);
      end
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " busy_after_done"}, busy, 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        c_exp = (v.c_kind == 0) ? (4*i + j + 1) : v.c_c;
        chk({tag, " result"}, acc[i][j], c_exp);
      end
    $display("run %s k=%0d done_at=s+%0d reads=%0d", tag, v.k, done_off, rd_cnt);
    if (hold) begin
      @(negedge clk);
      chk({tag, " restart_clear"}, pe_clr, 1);
    end
  endtask

  initial begin
    vecs[0] = '{4, 0, 0, 1'b0 ? 0 : 0, 0, 13, 0, 0};
    vecs[1] = '{1, 1, 2, 1, -3, 10, 1, -6};
    vecs[2] = '{0, 1, 7, 1, 7, 2, 1, 0};
    vecs[3] = '{2, 1, -128, 1, -128, 11, 1, -32768};
    vecs[4] = '{16, 1, 1, 1, 1, 25, 1, 16};
    vecs[5] = '{3, 1, -1, 1, 5, 12, 1, -15};

    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    repeat (3) @(negedge clk);
    chk("reset pe_clr", pe_clr, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset rd_en", rd_en, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset x_edge", x_edge, 0);
    chk("reset y_edge", y_edge, 0);
    chk("reset res_valid", res_valid, 0);
    $display("reset checked");
    rst = 1'b0;
    @(negedge clk);
    chk("idle pe_clr", pe_clr, 0);

    for (int t = 0; t < 6; t++) run(vecs[t], $sformatf("vec%0d", t), 1'b0);

    // Reset during the second FEED cycle, then a clean identity run.
    load(vecs[0]);
    @(negedge clk);
    k_len = KW'(4);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst rd_en_before", rd_en, 1);
    chk("midrst rd_addr_before", rd_addr, 1);
    rst = 1'b1;
    #1 chk("midrst pe_clr", pe_clr, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst rd_en", rd_en, 0);
    chk("midrst x_edge", x_edge, 0);
    chk("midrst y_edge", y_edge, 0);
    $display("mid-feed reset checked");
    run(vecs[0], "after_rst", 1'b0);

    // start held high: one run, DONE-cycle start ignored, restart only from IDLE.
    run(vecs[0], "hold", 1'b1);
    start = 1'b0;
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    chk("hold drain_busy", busy, 0);
    $display("held-start run checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
